seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Recovers displayed distance digits from a multiplexed 7-segment display bus: samples segment lines and one-hot digit selects, decodes each settled pattern back to a BCD nibble, and publishes a complete multi-digit frame with a valid pulse. It is the inverse of the team's BCD-to-segment encoder. It sits on the display side of the telemeter, for self-check and readback of what the display actually shows.

## Interface
- POLARITE, 1, segment polarity of iSeg: 1 = common anode (active-low segments), 0 = common cathode (active-high).
- NB_DIGITS, 4, number of multiplexed digits.
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is accepted (≥2).
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- iSeg  in  [0:6]  segment lines a..g (bit 0 = a), polarity per POLARITE.
- iDigSel  in  [NB_DIGITS-1:0]  digit enables, active-high, one-hot when a digit is driven; index 0 = least significant digit.
- oBcd  out  [4*NB_DIGITS-1:0]  last published frame; digit i in oBcd[4i+3:4i].
- oValid  out  1  one-cycle pulse: oBcd updated this cycle.
- oErr  out  1  one-cycle pulse: settled digit carried an undecodable pattern.

## Operation
- Input stage: iSeg and iDigSel registered once. Normalised seg = POLARITE ? ~iSeg : iSeg (abcdefg, 1 = lit).
- Decode (exact inverse of encoder): 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9, 0000000→4'hF (blank, valid). Any other pattern is invalid.
- Stability counter: if registered iDigSel not one-hot (zero or multiple bits), counter = 0, no capture. Else if (seg, sel) equals previous registered sample, counter increments, saturating at STABLE_CYCLES; otherwise counter = 1.
- Capture event: the cycle counter goes from STABLE_CYCLES-1 to STABLE_CYCLES. Valid pattern: shadow[idx] ← nibble, mask[idx] ← 1. Invalid: oErr pulse, shadow and mask unchanged, and the frame is poisoned (frame returns to IDLE, mask cleared).
- Saturation means each held digit captures exactly once per dwell.
- Frame FSM:
  - IDLE: capture of digit 0 → COLLECT with mask = 1 at bit 0. Captures of other digits are ignored.
  - COLLECT: captures set mask bits. Recapture of an already-set digit other than 0 overwrites its nibble. Capture of digit 0 restarts the frame (mask = only bit 0). When mask is all ones → PUBLISH.
  - PUBLISH (one cycle): oBcd ← shadow, oValid = 1, mask ← 0 → IDLE. A capture arriving during PUBLISH is processed as in IDLE.
- NB_DIGITS=1: digit-0 capture completes the frame immediately.

## Timing
- Reset values: oBcd = 0, oValid = 0, oErr = 0, FSM = IDLE, mask = 0, counter = 0, input registers = 0. Reset mid-frame discards all partial captures; no oValid is produced for that frame.
- Capture latency: a pattern and select first present at the inputs before edge t is captured at edge t+STABLE_CYCLES.
- oErr is high for the cycle following the capture edge.
- Final digit captured at edge T → PUBLISH state (oValid high, new oBcd visible) in the cycle after edge T+1.
- oBcd holds its value between publications. oValid is never high on two consecutive cycles.

## Structure
- Shared package: segment pattern constants SEG_0..SEG_9, SEG_BLANK, BLANK_CODE = 4'hF, frame-state encoding (IDLE, COLLECT, PUBLISH).
- One sub-module: seg7_pattern_decode (combinational pattern → {valid, nibble}); the stability counter, FSM and registers stay in the top module.

## Test plan
All scenarios use POLARITE=1, NB_DIGITS=4, STABLE_CYCLES=4.
- Scan digits 0..3 with patterns for 4, 3, 2, 1 (raw iSeg = ~pattern), 8 cycles each → single oValid pulse, oBcd = 16'h1234, oErr never high.
- Same scan but digit 2 held only 3 cycles → no capture of digit 2, no oValid. A following full scan at 8 cycles each → oValid, correct value.
- Digit 2 shows normalised 1001001 for 6 cycles → exactly one oErr pulse, no oValid for that frame, oBcd keeps its previous value.
- Digit 3 blank (raw iSeg = 7'b1111111), others 5, 6, 7 → oBcd = 16'hF765.
- iDigSel = 4'b0000 or 4'b0011 for 10 cycles with a valid pattern → no capture, no oValid, no oErr; counter restarts when a one-hot select returns.
- rst_n low for 1 cycle after digits 0 and 1 are captured → outputs 0. The next oValid requires a full new scan starting at digit 0.

Source files
------------

// File: rtl/seg7_scan_decoder_pkg.sv
// Shared definitions for the multiplexed 7-segment readback path:
// segment patterns (abcdefg, bit 6 = a, 1 = lit), blank code and frame states.
package seg7_scan_decoder_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    PUBLISH
  } frame_state_t;

  // Bus carries a at index 0; patterns carry a at the MSB, lit = 1.
  function automatic logic [6:0] normalise_seg(input logic [0:6] raw,
                                               input logic       active_low);
    logic [6:0] lit;
    lit = {raw[0], raw[1], raw[2], raw[3], raw[4], raw[5], raw[6]};
    return active_low ? ~lit : lit;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the BCD-to-segment encoder: lit pattern -> {valid, nibble}.
module seg7_pattern_decode
  import seg7_scan_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] nibble
);

  always_comb begin
    valid  = 1'b1;
    nibble = BLANK_CODE;
    case (seg)
      SEG_0:     nibble = 4'd0;
      SEG_1:     nibble = 4'd1;
      SEG_2:     nibble = 4'd2;
      SEG_3:     nibble = 4'd3;
      SEG_4:     nibble = 4'd4;
      SEG_5:     nibble = 4'd5;
      SEG_6:     nibble = 4'd6;
      SEG_7:     nibble = 4'd7;
      SEG_8:     nibble = 4'd8;
      SEG_9:     nibble = 4'd9;
      SEG_BLANK: nibble = BLANK_CODE;
      default: begin
        valid  = 1'b0;
        nibble = BLANK_CODE;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers BCD digits from a multiplexed 7-segment bus: per-digit settling
// filter, pattern decode and a frame collector that publishes complete frames.
module seg7_scan_decoder
  import seg7_scan_decoder_pkg::*;
#(
  parameter int POLARITE      = 1,
  parameter int NB_DIGITS     = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [0:6]             iSeg,
  input  logic [NB_DIGITS-1:0]   iDigSel,
  output logic [4*NB_DIGITS-1:0] oBcd,
  output logic                   oValid,
  output logic                   oErr
);

  localparam int IDXW = (NB_DIGITS > 1) ? $clog2(NB_DIGITS) : 1;
  localparam int CNTW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(STABLE_CYCLES);

  logic [0:6]                 seg_q;
  logic [NB_DIGITS-1:0]       sel_q;
  logic [0:6]                 seg_prev;
  logic [NB_DIGITS-1:0]       sel_prev;
  logic [CNTW-1:0]            cnt;
  logic [CNTW-1:0]            cnt_next;
  logic [6:0]                 seg_lit;
  logic                       dec_valid;
  logic [3:0]                 dec_nib;
  logic [IDXW-1:0]            idx;
  logic                       sel_onehot;
  logic                       capture;
  frame_state_t               state;
  logic [NB_DIGITS-1:0]       mask;
  logic [NB_DIGITS-1:0][3:0]  shadow;

  assign seg_lit = normalise_seg(seg_q, POLARITE != 0);

  seg7_pattern_decode u_decode (
    .seg    (seg_lit),
    .valid  (dec_valid),
    .nibble (dec_nib)
  );

  always_comb begin
    sel_onehot = $onehot(sel_q);
    idx        = '0;
    for (int unsigned i = 0; i < NB_DIGITS; i++) begin
      if (sel_q[i]) idx = IDXW'(i);
    end
  end

  // Saturation makes the STABLE-1 -> STABLE step happen once per dwell.
  always_comb begin
    cnt_next = '0;
    if (sel_onehot) begin
      if (seg_q == seg_prev && sel_q == sel_prev)
        cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      else
        cnt_next = CNTW'(1);
    end
    capture = (cnt == CNT_MAX - 1'b1) && (cnt_next == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q    <= '0;
      sel_q    <= '0;
      seg_prev <= '0;
      sel_prev <= '0;
      cnt      <= '0;
      state    <= IDLE;
      mask     <= '0;
      shadow   <= '0;
      oBcd     <= '0;
      oValid   <= 1'b0;
      oErr     <= 1'b0;
    end else begin
      seg_q    <= iSeg;
      sel_q    <= iDigSel;
      seg_prev <= seg_q;
      sel_prev <= sel_q;
      cnt      <= cnt_next;
      oErr     <= capture && !dec_valid;
      oValid   <= 1'b0;

      case (state)
        COLLECT: begin
          if (mask == '1) begin
            state  <= PUBLISH;
            oBcd   <= shadow;
            oValid <= 1'b1;
          end else if (capture) begin
            if (!dec_valid) begin
              state <= IDLE;
              mask  <= '0;
            end else if (idx == '0) begin
              mask      <= NB_DIGITS'(1);
              shadow[0] <= dec_nib;
            end else begin
              mask[idx]   <= 1'b1;
              shadow[idx] <= dec_nib;
            end
          end
        end
        // PUBLISH lasts one cycle and otherwise behaves exactly like IDLE.
        default: begin
          state <= IDLE;
          mask  <= '0;
          if (capture && dec_valid && idx == '0) begin
            state     <= COLLECT;
            mask      <= NB_DIGITS'(1);
            shadow[0] <= dec_nib;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: dwell-level reference model feeds an
// event queue; a monitor compares every oValid/oErr pulse and the held oBcd.
module tb_seg7_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [0:6]      iSeg;
  logic [ND-1:0]   iDigSel;
  logic [4*ND-1:0] oBcd;
  logic            oValid;
  logic            oErr;

  seg7_scan_decoder #(
    .POLARITE      (1),
    .NB_DIGITS     (ND),
    .STABLE_CYCLES (SC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .iSeg    (iSeg),
    .iDigSel (iDigSel),
    .oBcd    (oBcd),
    .oValid  (oValid),
    .oErr    (oErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              is_err;
    logic [4*ND-1:0] val;
  } ev_t;

  ev_t q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  // Lit patterns abcdefg (a = MSB); index 10 is blank.
  logic [6:0] pat [0:10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b0000000};

  bit            m_active = 0;
  logic [ND-1:0] m_have   = '0;
  logic [3:0]    m_val [ND];
  logic [0:6]    last_seg = '1;
  logic [ND-1:0] last_sel = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [0:6] to_raw(input logic [6:0] lit);
    logic [0:6] r;
    for (int k = 0; k < 7; k++) r[k] = ~lit[6-k];
    return r;
  endfunction

  function automatic logic [6:0] lit_of(input logic [3:0] nib);
    return (nib == 4'hF) ? pat[10] : pat[nib];
  endfunction

  function automatic void decode_ref(input logic [6:0] lit, output bit ok, output logic [3:0] nib);
    ok  = 0;
    nib = 4'hF;
    for (int d = 0; d <= 10; d++) begin
      if (lit == pat[d]) begin
        ok  = 1;
        nib = (d == 10) ? 4'hF : 4'(d);
      end
    end
  endfunction

  task automatic drive(input logic [ND-1:0] sel, input logic [0:6] raw, input int len);
    iDigSel = sel;
    iSeg    = raw;
    repeat (len) @(posedge clk);
    #1;
  endtask

  // A dwell of len cycles on one (pattern, select) pair; at least SC cycles
  // with a one-hot select yields exactly one capture of that digit.
  task automatic dwell(input logic [ND-1:0] sel, input logic [6:0] lit, input int len);
    logic [0:6]      raw;
    bit              ok;
    logic [3:0]      nib;
    int              idx;
    logic [4*ND-1:0] v;
    raw = to_raw(lit);
    if (raw == last_seg && sel == last_sel) drive('0, raw, 1);
    if ($countones(sel) == 1 && len >= SC) begin
      idx = 0;
      for (int i = 0; i < ND; i++) if (sel[i]) idx = i;
      decode_ref(lit, ok, nib);
      if (!ok) begin
        q.push_back('{is_err: 1'b1, val: '0});
        m_active = 0;
        m_have   = '0;
      end else if (idx == 0) begin
        m_active = 1;
        m_have   = ND'(1);
        m_val[0] = nib;
      end else if (m_active) begin
        m_have[idx] = 1'b1;
        m_val[idx]  = nib;
      end
      if (m_active && m_have == '1) begin
        for (int i = 0; i < ND; i++) v[4*i +: 4] = m_val[i];
        q.push_back('{is_err: 1'b0, val: v});
        m_active = 0;
        m_have   = '0;
      end
    end
    drive(sel, raw, len);
    last_seg = raw;
    last_sel = sel;
  endtask

  task automatic scan(input logic [15:0] code, input int l0, input int l1, input int l2, input int l3);
    dwell(4'b0001, lit_of(code[3:0]),   l0);
    dwell(4'b0010, lit_of(code[7:4]),   l1);
    dwell(4'b0100, lit_of(code[11:8]),  l2);
    dwell(4'b1000, lit_of(code[15:12]), l3);
  endtask

  task automatic do_reset();
    dwell('0, pat[8], 4);
    rst_n   = 1'b0;
    iDigSel = '0;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    m_active = 0;
    m_have   = '0;
    last_sel = '0;
  endtask

  // Monitor: rst_n is sampled at the edge, outputs at the following negedge.
  initial begin
    bit              r;
    bit              pv;
    logic [4*ND-1:0] hold;
    ev_t             e;
    pv   = 0;
    hold = '0;
    forever begin
      @(posedge clk);
      r = rst_n;
      @(negedge clk);
      if (!r) begin
        chk("reset_bcd", 32'(oBcd), 32'h0);
        chk("reset_valid", 32'(oValid), 32'h0);
        chk("reset_err", 32'(oErr), 32'h0);
        hold = '0;
        pv   = 0;
      end else begin
        if (oValid) begin
          chk("valid_back_to_back", 32'(pv), 32'h0);
          if (q.size() == 0) begin
            chk("spurious_valid_queue_len", 32'h0, 32'h1);
          end else begin
            e = q.pop_front();
            chk("event_kind_valid", 32'(e.is_err), 32'h0);
            chk("frame_value", 32'(oBcd), 32'(e.val));
            hold = e.val;
          end
        end
        if (oErr) begin
          if (q.size() == 0) begin
            chk("spurious_err_queue_len", 32'h0, 32'h1);
          end else begin
            e = q.pop_front();
            chk("event_kind_err", 32'(e.is_err), 32'h1);
          end
        end
        chk("bcd_hold", 32'(oBcd), 32'(hold));
        pv = oValid;
      end
    end
  end

  initial begin
    logic [ND-1:0] sel;
    logic [6:0]    lit;
    rst_n   = 1'b0;
    iSeg    = '1;
    iDigSel = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    scan(16'h1234, 8, 8, 8, 8);
    scan(16'h1234, 8, 8, 3, 8);
    scan(16'h5678, 8, 8, 8, 8);

    dwell(4'b0001, pat[9], 8);
    dwell(4'b0010, pat[0], 8);
    dwell(4'b0100, 7'b1001001, 6);
    dwell(4'b1000, pat[2], 8);

    scan(16'hF765, 8, 8, 8, 8);

    dwell(4'b0000, pat[3], 10);
    dwell(4'b0011, pat[3], 10);
    scan(16'h4321, 8, 8, 8, 8);

    dwell(4'b0001, pat[7], 8);
    dwell(4'b0010, pat[8], 8);
    do_reset();
    dwell(4'b0100, pat[0], 8);
    dwell(4'b1000, pat[9], 8);
    scan(16'h9087, 8, 8, 8, 8);

    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 19) == 0) do_reset();
      for (int i = 0; i < ND; i++) begin
        sel = ND'(1) << i;
        if ($urandom_range(0, 9) == 0) sel = ND'($urandom);
        if ($urandom_range(0, 19) < 17) lit = pat[$urandom_range(0, 10)];
        else lit = 7'($urandom);
        dwell(sel, lit, $urandom_range(2, 8));
      end
    end

    dwell('0, pat[8], 12);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
